// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches an 8-word block from pipelined main memory
// and writes it into the data array, then strobes the tag write.
// Optional critical-word-first ordering: define FILL_CRITICAL_WORD_FIRST_EN.
module cache_fill_fsm #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [AWIDTH-1:0] miss_address,
  input  logic [DWIDTH-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_en,
  output logic [AWIDTH-1:0] memory_address,
  output logic              write_data_array,
  output logic [2:0]        word_index,
  output logic [DWIDTH-1:0] fill_data,
  output logic              write_tag_array
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        issue_cnt_q, issue_cnt_d;
  logic [3:0]        recv_cnt_q, recv_cnt_d;
  // Only the block number is kept; the low nibble is rebuilt from the word offset,
  // so request addresses can never carry out of the block.
  logic [AWIDTH-5:0] base_q, base_d;
  logic [2:0]        req_off;
  logic [2:0]        ret_off;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
  logic [2:0] start_q, start_d;

  always_comb begin
    start_d = start_q;
    if (state_q == IDLE && miss_detected) begin
      start_d = miss_address[3:1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_q <= 3'd0;
    end else begin
      start_q <= start_d;
    end
  end

  // 3-bit sum wraps modulo 8, giving the wrap-around fill order.
  assign req_off = start_q + issue_cnt_q[2:0];
  assign ret_off = start_q + recv_cnt_q[2:0];
`else
  assign req_off = issue_cnt_q[2:0];
  assign ret_off = recv_cnt_q[2:0];
`endif

  assign fill_data = memory_data;

  always_comb begin
    state_d          = state_q;
    issue_cnt_d      = issue_cnt_q;
    recv_cnt_d       = recv_cnt_q;
    base_d           = base_q;
    fsm_busy         = 1'b0;
    memory_en        = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = 3'd0;
    write_tag_array  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          issue_cnt_d = 4'd0;
          recv_cnt_d  = 4'd0;
          base_d      = miss_address[AWIDTH-1:4];
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        if (issue_cnt_q < 4'd8) begin
          memory_en      = 1'b1;
          memory_address = {base_q, req_off, 1'b0};
          issue_cnt_d    = issue_cnt_q + 4'd1;
        end
        // Completion is driven purely by counting returns, independent of latency.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_index       = ret_off;
          recv_cnt_d       = recv_cnt_q + 4'd1;
          if (recv_cnt_q == 4'd7) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= 4'd0;
      recv_cnt_q  <= 4'd0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
      base_q      <= base_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: pipelined memory model with configurable latency and a
// scoreboard of expected request addresses and data-array writes.
module tb_cache_fill_fsm;

  localparam int DW = 16;
  localparam int AW = 16;

`ifdef FILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic [DW-1:0] memory_data;
  logic          memory_data_valid;
  logic          fsm_busy;
  logic          memory_en;
  logic [AW-1:0] memory_address;
  logic          write_data_array;
  logic [2:0]    word_index;
  logic [DW-1:0] fill_data;
  logic          write_tag_array;

  always #5 clk = ~clk;

  cache_fill_fsm #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_en         (memory_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
  );

  typedef struct {
    logic [2:0]    idx;
    logic [DW-1:0] data;
    logic          tag;
  } wr_t;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } req_t;

  wr_t           exp_wr[$];
  logic [AW-1:0] exp_addr[$];
  req_t          pend[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int lat         = 4;
  int tag_seen    = 0;
  int wr_seen     = 0;
  bit stray       = 1'b0;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Expected request/write sequence for one block fill, derived from the miss address.
  task automatic push_expect(input logic [AW-1:0] addr);
    logic [AW-1:0] base;
    logic [AW-1:0] a;
    logic [2:0]    st;
    logic [2:0]    off;
    wr_t           w;
    base = addr & 16'hFFF0;
    st   = addr[3:1];
    for (int k = 0; k < 8; k++) begin
      off = CWF ? (st + 3'(k)) : 3'(k);
      a   = base | {12'h000, off, 1'b0};
      exp_addr.push_back(a);
      w.idx  = off;
      w.data = memf(a);
      w.tag  = (k == 7);
      exp_wr.push_back(w);
    end
  endtask

  // One clock: apply memory response for this cycle, then score the DUT outputs.
  task automatic cycle();
    req_t          r;
    wr_t           w;
    logic [AW-1:0] ea;
    @(posedge clk);
    @(negedge clk);
    if (stray) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
    end else if (lat == 0) begin
      memory_data_valid = memory_en;
      memory_data       = memory_en ? memf(memory_address) : 16'h0000;
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      r                 = pend.pop_front();
      memory_data_valid = 1'b1;
      memory_data       = memf(r.addr);
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'h0000;
    end
    #1;
    if (memory_en) begin
      vectors++;
      if (exp_addr.size() == 0) begin
        miscompares++;
        $display("FAIL req_addr: unexpected request got %h, none required (cyc %0d)", memory_address, cyc);
      end else begin
        ea = exp_addr.pop_front();
        if (memory_address !== ea) begin
          miscompares++;
          $display("FAIL req_addr: got %h required %h (cyc %0d)", memory_address, ea, cyc);
        end
      end
      if (lat > 0) begin
        r.due  = cyc + lat;
        r.addr = memory_address;
        pend.push_back(r);
      end
    end
    if (write_data_array) begin
      wr_seen++;
      vectors++;
      if (exp_wr.size() == 0) begin
        miscompares++;
        $display("FAIL data_write: unexpected write idx %0d, none required (cyc %0d)", word_index, cyc);
      end else begin
        w = exp_wr.pop_front();
        if (word_index !== w.idx || fill_data !== w.data || write_tag_array !== w.tag) begin
          miscompares++;
          $display("FAIL data_write: got idx %0d data %h tag %b required idx %0d data %h tag %b (cyc %0d)",
                   word_index, fill_data, write_tag_array, w.idx, w.data, w.tag, cyc);
        end
      end
    end else if (write_tag_array) begin
      vectors++;
      miscompares++;
      $display("FAIL tag_write: got tag strobe without data write, required none (cyc %0d)", cyc);
    end
    if (write_tag_array) tag_seen++;
    cyc++;
  endtask

  task automatic wait_idle(output int busy, output bit timeout);
    busy    = 0;
    timeout = 1'b0;
    while (fsm_busy) begin
      busy++;
      if (busy > 64) begin
        timeout = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic test_reset();
    rst               = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    cycle();
    cycle();
    vectors++;
    if (fsm_busy !== 1'b0 || memory_en !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got busy %b en %b wda %b wta %b required all 0",
               fsm_busy, memory_en, write_data_array, write_tag_array);
    end
    vectors++;
    if (memory_address !== 16'h0000 || word_index !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_values: got addr %h idx %0d required 0000 and 0", memory_address, word_index);
    end
    memory_data = 16'hBEEF;
    #1;
    vectors++;
    if (fill_data !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL reset_fill_data: got %h required beef", fill_data);
    end
    rst = 1'b1;
    cycle();
    vectors++;
    if (fsm_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got busy %b required 0", fsm_busy);
    end
  endtask

  task automatic test_fill(input logic [AW-1:0] addr, input int l);
    int b;
    bit to;
    int t0;
    lat = l;
    t0  = tag_seen;
    push_expect(addr);
    miss_detected = 1'b1;
    miss_address  = addr;
    cycle();
    miss_detected = 1'b0;
    vectors++;
    if (fsm_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_rise @%h: got %b required 1", addr, fsm_busy);
    end
    wait_idle(b, to);
    vectors++;
    if (to || b != 8 + l) begin
      miscompares++;
      $display("FAIL busy_cycles @%h lat %0d: got %0d (timeout %b) required %0d", addr, l, b, to, 8 + l);
    end
    vectors++;
    if (tag_seen - t0 != 1) begin
      miscompares++;
      $display("FAIL tag_count @%h: got %0d required 1", addr, tag_seen - t0);
    end
    vectors++;
    if (exp_wr.size() != 0 || exp_addr.size() != 0) begin
      miscompares++;
      $display("FAIL fill_complete @%h: got %0d writes %0d requests outstanding required 0",
               addr, exp_wr.size(), exp_addr.size());
    end
  endtask

  task automatic test_hold_miss();
    int b;
    bit to;
    int t0;
    lat = 4;
    t0  = tag_seen;
    push_expect(16'hFFFE);
    miss_detected = 1'b1;
    miss_address  = 16'hFFFE;
    cycle();
    wait_idle(b, to);
    vectors++;
    if (to || b != 12) begin
      miscompares++;
      $display("FAIL hold_busy_cycles: got %0d (timeout %b) required 12", b, to);
    end
    vectors++;
    if (tag_seen - t0 != 1 || exp_addr.size() != 0) begin
      miscompares++;
      $display("FAIL hold_single_fill: got %0d tags %0d requests outstanding required 1 and 0",
               tag_seen - t0, exp_addr.size());
    end
    push_expect(16'hFFFE);
    cycle();
    miss_detected = 1'b0;
    vectors++;
    if (fsm_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL back_to_back_start: got busy %b required 1", fsm_busy);
    end
    wait_idle(b, to);
    vectors++;
    if (to || b != 12 || tag_seen - t0 != 2 || exp_wr.size() != 0) begin
      miscompares++;
      $display("FAIL back_to_back_fill: got busy %0d tags %0d left %0d required 12, 2, 0",
               b, tag_seen - t0, exp_wr.size());
    end
  endtask

  task automatic test_reset_midfill();
    int w0;
    int t0;
    int g;
    lat = 4;
    w0  = wr_seen;
    t0  = tag_seen;
    push_expect(16'h1236);
    miss_detected = 1'b1;
    miss_address  = 16'h1236;
    cycle();
    miss_detected = 1'b0;
    g = 0;
    while (wr_seen - w0 < 3 && g < 40) begin
      cycle();
      g++;
    end
    vectors++;
    if (wr_seen - w0 != 3) begin
      miscompares++;
      $display("FAIL midfill_writes: got %0d writes required 3", wr_seen - w0);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (fsm_busy !== 1'b0 || memory_en !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
      miscompares++;
      $display("FAIL midfill_reset_strobes: got busy %b en %b wda %b wta %b required all 0",
               fsm_busy, memory_en, write_data_array, write_tag_array);
    end
    vectors++;
    if (memory_address !== 16'h0000 || word_index !== 3'd0) begin
      miscompares++;
      $display("FAIL midfill_reset_values: got addr %h idx %0d required 0000 and 0", memory_address, word_index);
    end
    exp_wr.delete();
    exp_addr.delete();
    pend.delete();
    cycle();
    cycle();
    rst = 1'b1;
    vectors++;
    if (tag_seen != t0) begin
      miscompares++;
      $display("FAIL midfill_tag: got %0d tag strobes required 0", tag_seen - t0);
    end
    test_fill(16'h0040, 4);
  endtask

  task automatic test_stray_valid();
    int t0;
    t0    = tag_seen;
    stray = 1'b1;
    repeat (6) begin
      cycle();
      vectors++;
      if (fsm_busy !== 1'b0 || write_data_array !== 1'b0 || write_tag_array !== 1'b0 || fill_data !== memory_data) begin
        miscompares++;
        $display("FAIL stray_valid: got busy %b wda %b wta %b fill %h required 0 0 0 %h",
                 fsm_busy, write_data_array, write_tag_array, fill_data, memory_data);
      end
    end
    stray = 1'b0;
    cycle();
    vectors++;
    if (fsm_busy !== 1'b0 || tag_seen != t0) begin
      miscompares++;
      $display("FAIL stray_state: got busy %b tags %0d required 0 and 0", fsm_busy, tag_seen - t0);
    end
    test_fill(16'h2000, 3);
  endtask

  initial begin
    test_reset();
    test_fill(16'h1236, 4);
    test_fill(16'h0E0E, 2);
    test_fill(16'h5A5A, 0);
    test_fill(16'h8001, 7);
    test_hold_miss();
    test_reset_midfill();
    test_stray_valid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
